encoder_speed_sampler: RTL and testbench

ENCODER_SPEED_SAMPLER -- requirements
Module: encoder_speed_sampler

---
 rtl/encoder_speed_sampler.sv | 202 ++++++++++++++++++++
 tb/tb_encoder_speed_sampler.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/encoder_speed_sampler.sv
// Quadrature encoder decoder with 32-bit position, per-interval velocity capture
// and an Avalon-MM register window with a coherent 32-bit position readout.
module encoder_speed_sampler (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        chipselect,
    input  logic [2:0]  address,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    input  logic        sample_tick,
    input  logic        enc_a,
    input  logic        enc_b,
    output logic        irq
);

    localparam logic [2:0] ADDR_STATUS   = 3'd0;
    localparam logic [2:0] ADDR_CONTROL  = 3'd1;
    localparam logic [2:0] ADDR_VELOCITY = 3'd2;
    localparam logic [2:0] ADDR_POS_LO   = 3'd3;
    localparam logic [2:0] ADDR_POS_HI   = 3'd4;
    localparam logic [2:0] ADDR_ERR      = 3'd5;
    localparam logic [2:0] ADDR_POS_CLR  = 3'd6;

    localparam logic [1:0] STEP_FWD = 2'b01;
    localparam logic [1:0] STEP_REV = 2'b11;

    // Raw phases packed as {A, B}
    logic [1:0] enc_raw;
    logic [1:0] enc_sync;
    assign enc_raw = {enc_a, enc_b};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= enc_raw[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign enc_sync[gi] = sync_reg;
        end
    endgenerate

    logic [1:0]  prev_reg;
    logic [31:0] position_reg;
    logic [15:0] delta_reg;
    logic [15:0] velocity_reg;
    logic [7:0]  err_count_reg;
    logic [15:0] shadow_reg;
    logic        sample_ready_reg;
    logic        overrun_reg;
    logic [2:0]  control_reg;
    logic [15:0] readdata_reg;

    logic irq_enable;
    logic invert;
    logic count_en;
    assign irq_enable = control_reg[0];
    assign invert     = control_reg[1];
    assign count_en   = control_reg[2];

    logic bus_wr;
    logic bus_rd;
    logic wr_status;
    logic wr_control;
    logic wr_err_clr;
    logic wr_pos_clr;
    logic rd_pos_lo;
    assign bus_wr     = chipselect & ~write_n;
    assign bus_rd     = chipselect & write_n;
    assign wr_status  = bus_wr && (address == ADDR_STATUS);
    assign wr_control = bus_wr && (address == ADDR_CONTROL);
    assign wr_err_clr = bus_wr && (address == ADDR_ERR);
    assign wr_pos_clr = bus_wr && (address == ADDR_POS_CLR);
    assign rd_pos_lo  = bus_rd && (address == ADDR_POS_LO);

    // Map the Gray sequence 00,10,11,01 onto 0..3 so a modulo-4 difference gives direction.
    logic [1:0] cur_idx;
    logic [1:0] prev_idx;
    logic [1:0] idx_diff;
    assign cur_idx  = {enc_sync[0], enc_sync[1] ^ enc_sync[0]};
    assign prev_idx = {prev_reg[0], prev_reg[1] ^ prev_reg[0]};
    assign idx_diff = cur_idx - prev_idx;

    logic [1:0] step;
    logic       err_event;
    always_comb begin
        step      = 2'b00;
        err_event = 1'b0;
        if (count_en) begin
            case (idx_diff)
                2'd1:    step = invert ? STEP_REV : STEP_FWD;
                2'd3:    step = invert ? STEP_FWD : STEP_REV;
                2'd2:    err_event = 1'b1;
                default: step = 2'b00;
            endcase
        end
    end

    logic [31:0] step_ext32;
    logic [15:0] step_ext16;
    assign step_ext32 = {{30{step[1]}}, step};
    assign step_ext16 = {{14{step[1]}}, step};

    // Clear-then-add so a same-cycle step survives a position clear
    logic [31:0] position_next;
    assign position_next = (wr_pos_clr ? 32'd0 : position_reg) + step_ext32;

    logic [16:0] delta_sum;
    logic [15:0] delta_sat;
    assign delta_sum = {delta_reg[15], delta_reg} + {step_ext16[15], step_ext16};
    always_comb begin
        delta_sat = delta_sum[15:0];
        if (delta_sum[16] != delta_sum[15]) begin
            delta_sat = delta_sum[16] ? 16'h8000 : 16'h7FFF;
        end
    end

    logic [7:0] err_count_next;
    always_comb begin
        err_count_next = err_count_reg;
        if (wr_err_clr) begin
            err_count_next = 8'd0;
        end else if (err_event && (err_count_reg != 8'hFF)) begin
            err_count_next = err_count_reg + 8'd1;
        end
    end

    logic [15:0] read_mux;
    always_comb begin
        read_mux = 16'h0000;
        case (address)
            ADDR_STATUS:   read_mux = {14'b0, overrun_reg, sample_ready_reg};
            ADDR_CONTROL:  read_mux = {13'b0, control_reg};
            ADDR_VELOCITY: read_mux = velocity_reg;
            ADDR_POS_LO:   read_mux = position_reg[15:0];
            ADDR_POS_HI:   read_mux = shadow_reg;
            ADDR_ERR:      read_mux = {8'b0, err_count_reg};
            default:       read_mux = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_reg         <= 2'b00;
            position_reg     <= 32'd0;
            delta_reg        <= 16'd0;
            velocity_reg     <= 16'd0;
            err_count_reg    <= 8'd0;
            shadow_reg       <= 16'd0;
            sample_ready_reg <= 1'b0;
            overrun_reg      <= 1'b0;
            control_reg      <= 3'b100;
            readdata_reg     <= 16'd0;
        end else begin
            prev_reg      <= enc_sync;
            position_reg  <= position_next;
            err_count_reg <= err_count_next;
            readdata_reg  <= read_mux;

            if (sample_tick) begin
                velocity_reg <= delta_reg;
                delta_reg    <= step_ext16;
            end else begin
                delta_reg    <= delta_sat;
            end

            // A tick beats a same-cycle status clear and leaves overrun untouched
            if (sample_tick) begin
                sample_ready_reg <= 1'b1;
                if (!wr_status && sample_ready_reg) begin
                    overrun_reg <= 1'b1;
                end
            end else if (wr_status) begin
                sample_ready_reg <= 1'b0;
                overrun_reg      <= 1'b0;
            end

            if (wr_control) begin
                control_reg <= writedata[2:0];
            end

            if (rd_pos_lo) begin
                shadow_reg <= position_reg[31:16];
            end
        end
    end

    logic unused_writedata;
    assign unused_writedata = ^writedata[15:3];

    assign readdata = readdata_reg;
    assign irq      = sample_ready_reg & irq_enable;

endmodule

// File: tb/tb_encoder_speed_sampler.sv
// Self-checking bench for encoder_speed_sampler: directed scenarios plus randomized
// encoder traffic compared against an edge-counting reference model.
module tb_encoder_speed_sampler;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        chipselect = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        write_n = 1'b1;
    logic [15:0] writedata = 16'd0;
    logic [15:0] readdata;
    logic        sample_tick = 1'b0;
    logic        enc_a = 1'b0;
    logic        enc_b = 1'b0;
    logic        irq;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          ph = 0;
    logic [31:0] m_pos;
    int          m_delta;
    int          m_vel;
    int          m_err;
    logic [15:0] m_shadow;
    logic        m_ready;
    logic        m_ovr;
    logic [2:0]  m_ctrl;

    encoder_speed_sampler dut (
        .clk(clk),
        .reset_n(reset_n),
        .chipselect(chipselect),
        .address(address),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .sample_tick(sample_tick),
        .enc_a(enc_a),
        .enc_b(enc_b),
        .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [1:0] ph_ab(input int p);
        case (p)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    task automatic model_reset();
        m_pos = 32'd0; m_delta = 0; m_vel = 0; m_err = 0; m_shadow = 16'd0;
        m_ready = 1'b0; m_ovr = 1'b0; m_ctrl = 3'b100;
    endtask

    task automatic model_step(input int dir);
        int s;
        if (!m_ctrl[2]) return;
        s = m_ctrl[1] ? -dir : dir;
        m_pos = m_pos + s;
        m_delta = m_delta + s;
        if (m_delta > 32767) m_delta = 32767;
        if (m_delta < -32768) m_delta = -32768;
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic move(input int dir);
        ph = (ph + dir + 4) % 4;
        {enc_a, enc_b} = ph_ab(ph);
        @(posedge clk); #1;
        model_step(dir);
    endtask

    task automatic toggle_both();
        ph = (ph + 2) % 4;
        {enc_a, enc_b} = ph_ab(ph);
        @(posedge clk); #1;
        if (m_ctrl[2] && m_err < 255) m_err++;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic settle();
        idle(6);
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
        case (a)
            3'd0: begin m_ready = 1'b0; m_ovr = 1'b0; end
            3'd1: m_ctrl = d[2:0];
            3'd5: m_err = 0;
            3'd6: m_pos = 32'd0;
            default: ;
        endcase
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        @(posedge clk); #1;
        d = readdata;
        chipselect = 1'b0;
        if (a == 3'd3) m_shadow = m_pos[31:16];
    endtask

    task automatic tick();
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        m_vel = m_delta; m_delta = 0;
        if (m_ready) m_ovr = 1'b1;
        m_ready = 1'b1;
    endtask

    task automatic do_reset(input int start_ph);
        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; sample_tick = 1'b0;
        ph = start_ph;
        {enc_a, enc_b} = ph_ab(ph);
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
        if (start_ph == 1) model_step(1);
        settle();
    endtask

    task automatic test_reset();
        logic [15:0] d;
        logic [15:0] exp_vals [8];
        model_reset();
        #3;
        checks++;
        if (readdata !== 16'h0000 || irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got readdata=%h irq=%b expected 0000/0", readdata, irq);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        settle();
        exp_vals = '{16'h0000, 16'h0004, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), d);
            checks++;
            if (d !== exp_vals[a]) begin
                errors++;
                $display("FAIL reset_reg%0d: got %h expected %h", a, d, exp_vals[a]);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_forward();
        logic [15:0] d;
        for (int i = 0; i < 8; i++) move(1);
        settle();
        tick();
        bus_write(3'd1, 16'h0005);
        bus_read(3'd2, d);
        checks++;
        if (d !== 16'h0008) begin errors++; $display("FAIL fwd_velocity: got %h expected 0008", d); end
        bus_read(3'd0, d);
        checks++;
        if (d !== 16'h0001) begin errors++; $display("FAIL fwd_status: got %h expected 0001", d); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL fwd_irq: got %b expected 1", irq); end
        $display("test_forward: velocity=%h", 16'(m_vel));
    endtask

    task automatic test_reverse();
        logic [15:0] d;
        do_reset(0);
        for (int i = 0; i < 5; i++) move(-1);
        settle();
        tick();
        bus_read(3'd2, d);
        checks++;
        if (d !== 16'hFFFB) begin errors++; $display("FAIL rev_velocity: got %h expected fffb", d); end
        bus_read(3'd3, d);
        checks++;
        if (d !== 16'hFFFB) begin errors++; $display("FAIL rev_pos_lo: got %h expected fffb", d); end
        bus_read(3'd4, d);
        checks++;
        if (d !== 16'hFFFF) begin errors++; $display("FAIL rev_pos_hi: got %h expected ffff", d); end
        $display("test_reverse: position=%h", m_pos);
    endtask

    task automatic test_overrun();
        logic [15:0] d;
        bus_write(3'd1, 16'h0005);
        bus_write(3'd0, 16'h0000);
        tick();
        tick();
        bus_read(3'd0, d);
        checks++;
        if (d !== 16'h0003) begin errors++; $display("FAIL ovr_status: got %h expected 0003", d); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL ovr_irq_set: got %b expected 1", irq); end
        bus_write(3'd0, 16'hFFFF);
        bus_read(3'd0, d);
        checks++;
        if (d !== 16'h0000) begin errors++; $display("FAIL ovr_cleared: got %h expected 0000", d); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL ovr_irq_clr: got %b expected 0", irq); end
        $display("test_overrun done");
    endtask

    task automatic test_errors();
        logic [15:0] d;
        for (int i = 0; i < 3; i++) toggle_both();
        settle();
        bus_read(3'd5, d);
        checks++;
        if (d !== 16'd3) begin errors++; $display("FAIL err_count3: got %h expected 0003", d); end
        bus_read(3'd3, d);
        checks++;
        if (d !== m_pos[15:0]) begin errors++; $display("FAIL err_pos: got %h expected %h", d, m_pos[15:0]); end
        bus_write(3'd5, 16'h1234);
        bus_read(3'd5, d);
        checks++;
        if (d !== 16'd0) begin errors++; $display("FAIL err_clear: got %h expected 0000", d); end
        for (int i = 0; i < 260; i++) toggle_both();
        settle();
        bus_read(3'd5, d);
        checks++;
        if (d !== 16'(m_err) || m_err != 255) begin
            errors++; $display("FAIL err_saturate: got %h expected 00ff", d);
        end
        bus_write(3'd5, 16'h0000);
        $display("test_errors done");
    endtask

    task automatic test_control();
        logic [15:0] d;
        logic [15:0] pos_before;
        do_reset(0);
        bus_write(3'd1, 16'h0006);
        for (int i = 0; i < 4; i++) move(1);
        settle();
        bus_read(3'd3, d);
        checks++;
        if (d !== 16'hFFFC) begin errors++; $display("FAIL inv_pos_lo: got %h expected fffc", d); end
        bus_read(3'd4, d);
        checks++;
        if (d !== 16'hFFFF) begin errors++; $display("FAIL inv_pos_hi: got %h expected ffff", d); end
        bus_write(3'd1, 16'h0000);
        pos_before = m_pos[15:0];
        for (int i = 0; i < 4; i++) move(1);
        toggle_both(); toggle_both();
        settle();
        bus_read(3'd3, d);
        checks++;
        if (d !== pos_before) begin errors++; $display("FAIL cnt_dis_pos: got %h expected %h", d, pos_before); end
        bus_read(3'd5, d);
        checks++;
        if (d !== 16'd0) begin errors++; $display("FAIL cnt_dis_err: got %h expected 0000", d); end
        bus_write(3'd1, 16'h0004);
        tick();
        for (int i = 0; i < 40000; i++) move(1);
        settle();
        tick();
        bus_read(3'd2, d);
        checks++;
        if (d !== 16'h7FFF) begin errors++; $display("FAIL vel_saturate: got %h expected 7fff", d); end
        bus_read(3'd3, d);
        checks++;
        if (d !== m_pos[15:0]) begin errors++; $display("FAIL long_pos: got %h expected %h", d, m_pos[15:0]); end
        $display("test_control: position=%h", m_pos);
    endtask

    task automatic test_coincident();
        logic [15:0] d;
        bus_write(3'd0, 16'h0000);
        tick();
        address = 3'd0; chipselect = 1'b1; write_n = 1'b0; sample_tick = 1'b1;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1; sample_tick = 1'b0;
        m_vel = m_delta; m_delta = 0; m_ready = 1'b1;
        bus_read(3'd0, d);
        checks++;
        if (d !== {14'b0, m_ovr, m_ready}) begin
            errors++; $display("FAIL tick_wins: got %h expected %h", d, {14'b0, m_ovr, m_ready});
        end
        bus_write(3'd0, 16'h0000);
        bus_read(3'd0, d);
        checks++;
        if (d !== 16'h0000) begin errors++; $display("FAIL status_clear: got %h expected 0000", d); end
        $display("test_coincident done");
    endtask

    task automatic test_pos_clear();
        logic [15:0] d;
        ph = (ph + 1) % 4;
        {enc_a, enc_b} = ph_ab(ph);
        @(posedge clk);
        @(posedge clk); #1;
        address = 3'd6; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
        m_pos = 32'd0;
        model_step(1);
        settle();
        bus_read(3'd3, d);
        checks++;
        if (d !== m_pos[15:0] || m_pos != 32'd1) begin
            errors++; $display("FAIL clr_step_lo: got %h expected 0001", d);
        end
        bus_read(3'd4, d);
        checks++;
        if (d !== 16'h0000) begin errors++; $display("FAIL clr_step_hi: got %h expected 0000", d); end
        bus_write(3'd6, 16'h0000);
        bus_read(3'd3, d);
        checks++;
        if (d !== 16'h0000) begin errors++; $display("FAIL clr_plain: got %h expected 0000", d); end
        $display("test_pos_clear done");
    endtask

    task automatic test_readonly();
        logic [15:0] d;
        logic [2:0] ro_addr [4];
        logic [15:0] expv;
        for (int i = 0; i < 5; i++) move(-1);
        settle();
        tick();
        bus_read(3'd3, d);
        ro_addr = '{3'd2, 3'd3, 3'd4, 3'd7};
        for (int i = 0; i < 4; i++) bus_write(ro_addr[i], 16'($urandom));
        for (int i = 0; i < 4; i++) begin
            bus_read(ro_addr[i], d);
            case (i)
                0: expv = 16'(m_vel);
                1: expv = m_pos[15:0];
                2: expv = m_shadow;
                default: expv = 16'h0000;
            endcase
            checks++;
            if (d !== expv) begin
                errors++; $display("FAIL ro_write_addr%0d: got %h expected %h", ro_addr[i], d, expv);
            end
        end
        $display("test_readonly done");
    endtask

    task automatic test_reset_release();
        logic [15:0] d;
        do_reset(1);
        bus_read(3'd3, d);
        checks++;
        if (d !== 16'h0001) begin errors++; $display("FAIL release_step: got %h expected 0001", d); end
        $display("test_reset_release done");
    endtask

    task automatic test_reset_midcount();
        logic [15:0] d;
        bus_write(3'd1, 16'h0005);
        tick();
        address = 3'd3;
        for (int i = 0; i < 6; i++) move(1);
        reset_n = 1'b0;
        #1;
        checks++;
        if (readdata !== 16'h0000 || irq !== 1'b0) begin
            errors++; $display("FAIL async_reset: got readdata=%h irq=%b expected 0000/0", readdata, irq);
        end
        ph = 0;
        {enc_a, enc_b} = ph_ab(ph);
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
        settle();
        bus_read(3'd3, d);
        checks++;
        if (d !== 16'h0000) begin errors++; $display("FAIL midreset_pos: got %h expected 0000", d); end
        bus_read(3'd1, d);
        checks++;
        if (d !== 16'h0004) begin errors++; $display("FAIL midreset_ctrl: got %h expected 0004", d); end
        $display("test_reset_midcount done");
    endtask

    task automatic test_random();
        logic [15:0] d;
        int r;
        for (int seg = 0; seg < 6; seg++) begin
            bus_write(3'd1, {13'b0, ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom)});
            for (int i = 0; i < 60; i++) begin
                r = $urandom_range(0, 9);
                if (r <= 3) move(1);
                else if (r <= 6) move(-1);
                else if (r <= 8) idle(1);
                else toggle_both();
            end
            settle();
            tick();
            bus_read(3'd2, d);
            checks++;
            if (d !== 16'(m_vel)) begin errors++; $display("FAIL rnd%0d_vel: got %h expected %h", seg, d, 16'(m_vel)); end
            bus_read(3'd3, d);
            checks++;
            if (d !== m_pos[15:0]) begin errors++; $display("FAIL rnd%0d_pos_lo: got %h expected %h", seg, d, m_pos[15:0]); end
            bus_read(3'd4, d);
            checks++;
            if (d !== m_pos[31:16]) begin errors++; $display("FAIL rnd%0d_pos_hi: got %h expected %h", seg, d, m_pos[31:16]); end
            bus_read(3'd5, d);
            checks++;
            if (d !== 16'(m_err)) begin errors++; $display("FAIL rnd%0d_err: got %h expected %h", seg, d, 16'(m_err)); end
            bus_read(3'd0, d);
            checks++;
            if (d !== {14'b0, m_ovr, m_ready}) begin
                errors++; $display("FAIL rnd%0d_status: got %h expected %h", seg, d, {14'b0, m_ovr, m_ready});
            end
            checks++;
            if (irq !== (m_ready & m_ctrl[0])) begin
                errors++; $display("FAIL rnd%0d_irq: got %b expected %b", seg, irq, m_ready & m_ctrl[0]);
            end
            if ($urandom_range(0, 1) == 1) bus_write(3'd0, 16'h0000);
            $display("test_random seg %0d: ctrl=%b pos=%h vel=%0d err=%0d", seg, m_ctrl, m_pos, m_vel, m_err);
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_reverse();
        test_overrun();
        test_errors();
        test_control();
        test_coincident();
        test_pos_clear();
        test_readonly();
        test_reset_release();
        test_reset_midcount();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
